// File: rtl/pipeline_ctrl.sv
// Hazard and sequencing controller for the 5-stage RV32 pipeline.
// Resolves load-use stalls, MEM-stage redirects and multi-cycle MDU holds, and keeps perf counters.
//
// state    | meaning
// RUN      | normal issue; load-use detection active
// MDU_WAIT | MDU op held in EX; mdu_cnt cycles of stall remain
module pipeline_ctrl #(
    parameter int MDU_LATENCY = 32,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       rs1_id_ctrl,
    input  logic [4:0]       rs2_id_ctrl,
    input  logic             rs1_used_id_ctrl,
    input  logic             rs2_used_id_ctrl,
    input  logic [4:0]       rd_ex_ctrl,
    input  logic             mem_read_ex_ctrl,
    input  logic             mdu_start_ex_ctrl,
    input  logic             branch_mem_ctrl,
    output logic             stall_if,
    output logic             stall_id,
    output logic             stall_ex,
    output logic             flush_id,
    output logic             flush_ex,
    output logic             flush_mem,
    output logic             mdu_done,
    output logic             mdu_abort,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] redirect_cnt
);

    typedef enum logic {RUN, MDU_WAIT} state_t;

    localparam logic [7:0] MDU_LOAD = 8'(MDU_LATENCY - 1);

    state_t     state;
    logic [7:0] mdu_cnt;
    logic       load_use;

    assign load_use = mem_read_ex_ctrl && (rd_ex_ctrl != 5'd0) &&
                      ((rs1_used_id_ctrl && (rs1_id_ctrl == rd_ex_ctrl)) ||
                       (rs2_used_id_ctrl && (rs2_id_ctrl == rd_ex_ctrl)));

    // Priority: redirect > MDU > load-use; everything is held low while in reset.
    always_comb begin
        stall_if  = 1'b0;
        stall_id  = 1'b0;
        stall_ex  = 1'b0;
        flush_id  = 1'b0;
        flush_ex  = 1'b0;
        flush_mem = 1'b0;
        mdu_done  = 1'b0;
        mdu_abort = 1'b0;
        if (!rst) begin
            if (branch_mem_ctrl) begin
                flush_id  = 1'b1;
                flush_ex  = 1'b1;
                flush_mem = 1'b1;
                mdu_abort = (state == MDU_WAIT) || mdu_start_ex_ctrl;
            end else if (state == MDU_WAIT) begin
                if (mdu_cnt != 8'd0) begin
                    stall_if  = 1'b1;
                    stall_id  = 1'b1;
                    stall_ex  = 1'b1;
                    flush_mem = 1'b1;
                end else begin
                    mdu_done = 1'b1;
                end
            end else if (mdu_start_ex_ctrl) begin
                stall_if  = 1'b1;
                stall_id  = 1'b1;
                stall_ex  = 1'b1;
                flush_mem = 1'b1;
            end else if (load_use) begin
                stall_if = 1'b1;
                stall_id = 1'b1;
                flush_ex = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= RUN;
            mdu_cnt      <= 8'd0;
            stall_cnt    <= '0;
            redirect_cnt <= '0;
        end else begin
            if (branch_mem_ctrl) begin
                state        <= RUN;
                mdu_cnt      <= 8'd0;
                redirect_cnt <= redirect_cnt + CNT_W'(1);
            end else if (state == MDU_WAIT) begin
                if (mdu_cnt != 8'd0) begin
                    mdu_cnt <= mdu_cnt - 8'd1;
                end else begin
                    state <= RUN;
                end
            end else if (mdu_start_ex_ctrl) begin
                state   <= MDU_WAIT;
                mdu_cnt <= MDU_LOAD;
            end
            if (stall_if) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: per-cycle expected output vectors go through a scoreboard queue.
module tb_pipeline_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  rs1_id_ctrl, rs2_id_ctrl, rd_ex_ctrl;
    logic        rs1_used_id_ctrl, rs2_used_id_ctrl;
    logic        mem_read_ex_ctrl, mdu_start_ex_ctrl, branch_mem_ctrl;
    logic        stall_if, stall_id, stall_ex, flush_id, flush_ex, flush_mem, mdu_done, mdu_abort;
    logic [31:0] stall_cnt, redirect_cnt;

    int checks   = 0;
    int failures = 0;
    logic [7:0] exp_q[$];

    // Output vector bit order: stall_if stall_id stall_ex flush_id flush_ex flush_mem mdu_done mdu_abort
    localparam logic [7:0] O_NONE = 8'b0000_0000;
    localparam logic [7:0] O_LU   = 8'b1100_1000;
    localparam logic [7:0] O_MDU  = 8'b1110_0100;
    localparam logic [7:0] O_DONE = 8'b0000_0010;
    localparam logic [7:0] O_RED  = 8'b0001_1100;
    localparam logic [7:0] O_ABRT = 8'b0001_1101;

    pipeline_ctrl #(.MDU_LATENCY(4), .CNT_W(32)) dut (
        .clk(clk), .rst(rst),
        .rs1_id_ctrl(rs1_id_ctrl), .rs2_id_ctrl(rs2_id_ctrl),
        .rs1_used_id_ctrl(rs1_used_id_ctrl), .rs2_used_id_ctrl(rs2_used_id_ctrl),
        .rd_ex_ctrl(rd_ex_ctrl), .mem_read_ex_ctrl(mem_read_ex_ctrl),
        .mdu_start_ex_ctrl(mdu_start_ex_ctrl), .branch_mem_ctrl(branch_mem_ctrl),
        .stall_if(stall_if), .stall_id(stall_id), .stall_ex(stall_ex),
        .flush_id(flush_id), .flush_ex(flush_ex), .flush_mem(flush_mem),
        .mdu_done(mdu_done), .mdu_abort(mdu_abort),
        .stall_cnt(stall_cnt), .redirect_cnt(redirect_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] out_vec();
        return {stall_if, stall_id, stall_ex, flush_id, flush_ex, flush_mem, mdu_done, mdu_abort};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2, input logic u2,
                         input logic [4:0] rd, input logic mr, input logic ms, input logic br);
        rs1_id_ctrl = rs1; rs1_used_id_ctrl = u1;
        rs2_id_ctrl = rs2; rs2_used_id_ctrl = u2;
        rd_ex_ctrl  = rd;  mem_read_ex_ctrl = mr;
        mdu_start_ex_ctrl = ms; branch_mem_ctrl = br;
    endtask

    // Called just after a falling edge: drive, check mid-cycle, then advance to the next falling edge.
    task automatic cyc(input string tag, input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                       input logic u2, input logic [4:0] rd, input logic mr, input logic ms,
                       input logic br, input logic [7:0] exp);
        logic [7:0] e;
        exp_q.push_back(exp);
        drive(rs1, u1, rs2, u2, rd, mr, ms, br);
        #2;
        e = exp_q.pop_front();
        chk(tag, 32'(out_vec()), 32'(e));
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        drive(5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        chk("reset_outs", 32'(out_vec()), 32'(O_NONE));
        chk("reset_stall_cnt", stall_cnt, 32'd0);
        chk("reset_redirect_cnt", redirect_cnt, 32'd0);
        rst = 1'b0;

        cyc("lu_rs1",       5'd5, 1, 5'd0, 0, 5'd5, 1, 0, 0, O_LU);
        cyc("lu_after",     5'd5, 1, 5'd0, 0, 5'd0, 0, 0, 0, O_NONE);
        chk("lu_stall_cnt", stall_cnt, 32'd1);
        cyc("rd_zero",      5'd0, 1, 5'd0, 0, 5'd0, 1, 0, 0, O_NONE);
        cyc("rs2_unused",   5'd1, 1, 5'd7, 0, 5'd7, 1, 0, 0, O_NONE);
        cyc("non_load",     5'd9, 1, 5'd0, 0, 5'd9, 0, 0, 0, O_NONE);
        cyc("lu_rs2",       5'd1, 0, 5'd7, 1, 5'd7, 1, 0, 0, O_LU);
        chk("lu2_stall_cnt", stall_cnt, 32'd2);

        cyc("mdu_c0",       5'd3, 1, 5'd0, 0, 5'd3, 1, 1, 0, O_MDU);
        cyc("mdu_c1",       5'd3, 1, 5'd0, 0, 5'd3, 1, 1, 0, O_MDU);
        cyc("mdu_c2",       5'd0, 0, 5'd0, 0, 5'd4, 0, 1, 0, O_MDU);
        cyc("mdu_c3",       5'd0, 0, 5'd0, 0, 5'd4, 0, 1, 0, O_MDU);
        cyc("mdu_done",     5'd0, 0, 5'd0, 0, 5'd4, 0, 1, 0, O_DONE);
        chk("mdu_stall_cnt", stall_cnt, 32'd6);
        cyc("mdu_back_run", 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, O_NONE);

        cyc("abrt_c0",      5'd0, 0, 5'd0, 0, 5'd2, 0, 1, 0, O_MDU);
        cyc("abrt_c1",      5'd0, 0, 5'd0, 0, 5'd2, 0, 1, 0, O_MDU);
        cyc("abrt_redir",   5'd0, 0, 5'd0, 0, 5'd2, 0, 1, 1, O_ABRT);
        cyc("abrt_no_done", 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, O_NONE);
        chk("abrt_redirect_cnt", redirect_cnt, 32'd1);
        chk("abrt_stall_cnt", stall_cnt, 32'd8);

        cyc("redir_over_lu", 5'd6, 1, 5'd0, 0, 5'd6, 1, 0, 1, O_RED);
        chk("redir_lu_stall_cnt", stall_cnt, 32'd8);
        chk("redir_lu_redirect_cnt", redirect_cnt, 32'd2);
        cyc("redir_over_mdu", 5'd0, 0, 5'd0, 0, 5'd0, 0, 1, 1, O_ABRT);
        cyc("no_mdu_wait",    5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, O_NONE);
        chk("redir_mdu_redirect_cnt", redirect_cnt, 32'd3);

        cyc("rst_mdu_c0",   5'd0, 0, 5'd0, 0, 5'd0, 0, 1, 0, O_MDU);
        cyc("rst_mdu_c1",   5'd0, 0, 5'd0, 0, 5'd0, 0, 1, 0, O_MDU);
        drive(5'd0, 0, 5'd0, 0, 5'd0, 0, 1, 0);
        #2;
        chk("rst_pre_stall", 32'(out_vec()), 32'(O_MDU));
        rst = 1'b1;
        #1;
        chk("rst_async_outs", 32'(out_vec()), 32'(O_NONE));
        chk("rst_async_stall_cnt", stall_cnt, 32'd0);
        chk("rst_async_redirect_cnt", redirect_cnt, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        cyc("post_rst_idle", 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, O_NONE);
        cyc("post_rst_lu",   5'd8, 1, 5'd0, 0, 5'd8, 1, 0, 0, O_LU);
        cyc("post_rst_after", 5'd8, 1, 5'd0, 0, 5'd0, 0, 0, 0, O_NONE);
        chk("post_rst_stall_cnt", stall_cnt, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
